// File: rtl/camera_settings_controller.sv
// camera_settings_controller: debounced three-button camera settings editor
// with an exposure meter that grades the current settings against the scene light level.
module camera_settings_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ISO_MAX         = 14,
    parameter int SHUTTER_MAX     = 15,
    parameter int FOCAL_MAX       = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnMode,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic [3:0] sceneLevel,
    output logic [3:0] isoValue,
    output logic [3:0] shutterSpeedValue,
    output logic [3:0] focalLenghtValue,
    output logic [2:0] brightnessIndicatorValue,
    output logic [1:0] selectInput
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {S_ISO, S_SHUTTER, S_FOCAL, S_METER} state_t;

    state_t r_state, w_state_next;
    logic [2:0] w_raw, r_sync1, r_sync2, r_level, r_prev, r_pulse;
    logic [CW-1:0] r_cnt [3];
    logic w_mode, w_inc, w_dec;
    logic [3:0] w_iso_next, w_sh_next, w_foc_next;
    logic signed [5:0] w_err;
    logic [2:0] w_bright;

    function automatic logic [3:0] f_step(input logic [3:0] v, input logic [3:0] mx,
                                          input logic inc, input logic dec);
        return inc ? ((v >= mx) ? v : v + 4'd1) : dec ? ((v == 4'd0) ? v : v - 4'd1) : v;
    endfunction

    // bit 0 = mode, bit 1 = up, bit 2 = down
    assign w_raw = {btnDown, btnUp, btnMode};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_prev  <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_level;
            r_pulse <= r_level & ~r_prev;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A mode press wins over up/down; opposing up/down presses cancel out
    assign w_mode = r_pulse[0];
    assign w_inc  = r_pulse[1] & ~r_pulse[2] & ~w_mode;
    assign w_dec  = r_pulse[2] & ~r_pulse[1] & ~w_mode;

    always_comb begin
        w_state_next = w_mode ? state_t'(r_state + 2'd1) : r_state;
        w_iso_next   = (r_state == S_ISO)     ? f_step(isoValue, 4'(ISO_MAX), w_inc, w_dec) : isoValue;
        w_sh_next    = (r_state == S_SHUTTER) ? f_step(shutterSpeedValue, 4'(SHUTTER_MAX), w_inc, w_dec) : shutterSpeedValue;
        w_foc_next   = (r_state == S_FOCAL)   ? f_step(focalLenghtValue, 4'(FOCAL_MAX), w_inc, w_dec) : focalLenghtValue;
        w_err        = 6'(isoValue) + 6'(shutterSpeedValue) - 6'(focalLenghtValue) - 6'(sceneLevel);
        w_bright     = (w_err < -6'sd2) ? 3'd0 : (w_err > 6'sd2) ? 3'd4 : 3'(w_err + 6'sd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                  <= S_ISO;
            isoValue                 <= 4'd4;
            shutterSpeedValue        <= 4'd10;
            focalLenghtValue         <= 4'd6;
            brightnessIndicatorValue <= 3'd2;
        end else begin
            r_state                  <= w_state_next;
            isoValue                 <= w_iso_next;
            shutterSpeedValue        <= w_sh_next;
            focalLenghtValue         <= w_foc_next;
            brightnessIndicatorValue <= w_bright;
        end
    end

    assign selectInput = r_state;
endmodule

// File: tb/tb_camera_settings_controller.sv
// tb_camera_settings_controller: randomized press sequences checked against
// an arithmetic model of the settings and exposure meter.
module tb_camera_settings_controller;
    localparam int D = 16, IM = 14, SM = 15, FM = 11;

    logic clk = 0, rst_n = 0, bm = 0, bu = 0, bd = 0;
    logic [3:0] scene = 4'd8;
    logic [3:0] iso, sh, foc;
    logic [2:0] bright;
    logic [1:0] sel;

    int errors = 0, checks = 0;
    int m_mode, m_iso, m_sh, m_foc;

    camera_settings_controller dut (
        .clk(clk), .rst_n(rst_n), .btnMode(bm), .btnUp(bu), .btnDown(bd),
        .sceneLevel(scene), .isoValue(iso), .shutterSpeedValue(sh),
        .focalLenghtValue(foc), .brightnessIndicatorValue(bright), .selectInput(sel)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return v < 0 ? 0 : v > mx ? mx : v;
    endfunction

    function automatic int m_bright();
        int e = m_iso + m_sh - m_foc - int'(scene);
        return e < -2 ? 0 : e > 2 ? 4 : e + 2;
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_iso = 4; m_sh = 10; m_foc = 6;
    endfunction

    function automatic void m_apply(input bit m, input bit u, input bit d);
        int dl;
        if (m) m_mode = (m_mode + 1) % 4;
        else if (u != d && m_mode != 3) begin
            dl = u ? 1 : -1;
            if (m_mode == 0) m_iso = sat(m_iso + dl, IM);
            else if (m_mode == 1) m_sh = sat(m_sh + dl, SM);
            else m_foc = sat(m_foc + dl, FM);
        end
    endfunction

    task automatic check_vals(input string tag);
        chk({tag, ".sel"}, int'(sel), m_mode);
        chk({tag, ".iso"}, int'(iso), m_iso);
        chk({tag, ".sh"}, int'(sh), m_sh);
        chk({tag, ".foc"}, int'(foc), m_foc);
    endtask

    task automatic check_all(input string tag);
        check_vals(tag);
        chk({tag, ".bright"}, int'(bright), m_bright());
    endtask

    // Called #1 after a rising edge; checks the exact edge the press lands on
    task automatic press(input bit m, input bit u, input bit d, input string tag);
        {bm, bu, bd} = {m, u, d};
        repeat (D + 3) @(posedge clk);
        #1 check_vals({tag, ".early"});
        @(posedge clk);
        #1 m_apply(m, u, d);
        check_vals({tag, ".late"});
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1 {bm, bu, bd} = 3'b000;
        repeat (25) @(posedge clk);
        #1 check_all({tag, ".settle"});
    endtask

    task automatic set_scene(input int s, input string tag);
        scene = 4'(s);
        repeat (2) @(posedge clk);
        #1 chk(tag, int'(bright), m_bright());
    endtask

    initial begin
        int r;
        m_reset();
        repeat (3) @(posedge clk);
        #1 check_vals("reset");
        chk("reset.bright", int'(bright), 2);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        set_scene(8, "meter.s8");
        chk("meter.s8.code", int'(bright), 2);
        set_scene(0, "meter.s0");
        chk("meter.s0.code", int'(bright), 4);
        set_scene(15, "meter.s15");
        chk("meter.s15.code", int'(bright), 0);
        set_scene(8, "meter.back");

        for (int i = 0; i < 12; i++) press(0, 1, 0, "iso_up");
        chk("iso_up.max", int'(iso), 14);
        for (int i = 0; i < 16; i++) press(0, 0, 1, "iso_dn");
        chk("iso_dn.min", int'(iso), 0);

        bu = 1;
        repeat (D - 1) @(posedge clk);
        #1 bu = 0;
        repeat (30) @(posedge clk);
        #1 check_vals("glitch");

        for (int k = 0; k < 6; k++) begin
            bu = (k % 2 == 0);
            repeat ($urandom_range(1, D - 2)) @(posedge clk);
            #1;
        end
        bu = 1;
        repeat (30) @(posedge clk);
        #1 bu = 0;
        repeat (25) @(posedge clk);
        #1 m_apply(0, 1, 0);
        check_all("bounce");

        press(0, 1, 1, "updown");
        press(1, 0, 0, "mode1");
        press(1, 1, 0, "mode_up");
        chk("mode_up.sel", int'(sel), 2);
        press(1, 0, 0, "to_meter");
        press(0, 1, 0, "meter_up");
        press(0, 0, 1, "meter_dn");

        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) set_scene(int'($urandom_range(0, 15)), "rnd.scene");
            else if (r < 35) press(1, 0, 0, "rnd.mode");
            else if (r < 60) press(0, 1, 0, "rnd.up");
            else if (r < 85) press(0, 0, 1, "rnd.dn");
            else if (r < 92) press(0, 1, 1, "rnd.updn");
            else press(1, r[0], ~r[0], "rnd.mode_ud");
        end

        #3 rst_n = 0;
        #1 m_reset();
        check_vals("async_rst");
        chk("async_rst.bright", int'(bright), 2);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1 bm = 1;
        repeat (5) @(posedge clk);
        #3 rst_n = 0;
        #1 check_vals("abort_rst");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        repeat (D + 2) @(posedge clk);
        #1 check_vals("held.early");
        @(posedge clk);
        #1 m_apply(1, 0, 0);
        check_vals("held.late");
        bm = 0;
        repeat (25) @(posedge clk);
        #1 check_all("held.settle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
